pix_product_accumulator: RTL and testbench

//  Consumer end of the pixel multiplier output interface: takes products (with valid/start

---
 rtl/pix_accum_pkg.sv | 19 +
 rtl/pix_product_accumulator_if.sv | 51 +++++
 rtl/pix_sum_fifo.sv | 62 ++++++
 rtl/pix_product_accumulator.sv | 154 +++++++++++++++
 tb/tb_pix_product_accumulator.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pix_accum_pkg.sv
// Shared types and sizing helpers for the pixel product accumulator
// and the multiplier array top.
package pix_accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  localparam int DEF_BIT_WIDTH  = 8;
  localparam int DEF_NUM_TERMS  = 9;
  localparam int DEF_FIFO_DEPTH = 4;

  // Widest possible window sum: n products of 2*bw bits each.
  function automatic int acc_width(input int bw, input int n);
    return 2 * bw + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pix_product_accumulator_if.sv
// Product input, sum output and status bundle of the accumulator.
// master = multiplier/downstream side, slave = accumulator.
interface pix_product_accumulator_if
  import pix_accum_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int NUM_TERMS  = DEF_NUM_TERMS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

  localparam int ACC_WIDTH = acc_width(BIT_WIDTH, NUM_TERMS);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic [2*BIT_WIDTH-1:0] i_product;
  logic                   i_product_valid;
  logic                   i_product_start;
  logic                   o_enable;
  logic [ACC_WIDTH-1:0]   o_sum;
  logic                   o_sum_valid;
  logic                   i_sum_ready;
  logic [CNT_WIDTH-1:0]   o_fifo_count;
  logic                   o_protocol_err;
  logic                   o_overflow;

  modport master (
    output i_product,
    output i_product_valid,
    output i_product_start,
    output i_sum_ready,
    input  o_enable,
    input  o_sum,
    input  o_sum_valid,
    input  o_fifo_count,
    input  o_protocol_err,
    input  o_overflow
  );

  modport slave (
    input  i_product,
    input  i_product_valid,
    input  i_product_start,
    input  i_sum_ready,
    output o_enable,
    output o_sum,
    output o_sum_valid,
    output o_fifo_count,
    output o_protocol_err,
    output o_overflow
  );

endinterface

// File: rtl/pix_sum_fifo.sv
// Small first-word fall-through FIFO for completed window sums.
// A push into a full FIFO is accepted only when a pop frees the slot.
module pix_sum_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = empty ? '0 : mem[rd_ptr];
  assign count = cnt_q;

endmodule

// File: rtl/pix_product_accumulator.sv
// Sums NUM_TERMS framed products per kernel window and queues the
// completed sums for a valid/ready consumer, throttling upstream.
module pix_product_accumulator
  import pix_accum_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int NUM_TERMS  = DEF_NUM_TERMS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pix_product_accumulator_if.slave bus
);

  localparam int ACC_WIDTH = acc_width(BIT_WIDTH, NUM_TERMS);
  localparam int TW        = $clog2(NUM_TERMS + 1);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  acc_state_e           state_q;
  acc_state_e           state_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [TW-1:0]        cnt_q;
  logic [TW-1:0]        cnt_d;
  logic                 perr_q;
  logic                 perr_d;
  logic                 ovf_q;
  logic                 en_q;
  logic                 en_d;

  logic                 push;
  logic [ACC_WIDTH-1:0] push_data;
  logic [ACC_WIDTH-1:0] prod;
  logic                 last_term;

  logic [ACC_WIDTH-1:0] head;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        fifo_cnt;
  logic [CW-1:0]        fifo_cnt_d;
  logic                 pop_ok;
  logic                 push_ok;

  assign prod      = ACC_WIDTH'(bus.i_product);
  assign last_term = (cnt_q == TW'(NUM_TERMS - 1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    perr_d    = 1'b0;
    push      = 1'b0;
    push_data = acc_q + prod;
    if (bus.i_product_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.i_product_start) begin
            perr_d = 1'b1;
          end else if (NUM_TERMS == 1) begin
            push      = 1'b1;
            push_data = prod;
          end else begin
            state_d = ACCUM;
            acc_d   = prod;
            cnt_d   = TW'(1);
          end
        end
        ACCUM: begin
          // A start mid-window restarts with the new term
          if (bus.i_product_start) begin
            perr_d = 1'b1;
            if (NUM_TERMS == 1) begin
              push      = 1'b1;
              push_data = prod;
              state_d   = IDLE;
              acc_d     = '0;
              cnt_d     = '0;
            end else begin
              acc_d = prod;
              cnt_d = TW'(1);
            end
          end else if (last_term) begin
            push    = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = acc_q + prod;
            cnt_d = cnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop_ok  = ~empty & bus.i_sum_ready;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    fifo_cnt_d = fifo_cnt;
    if (push_ok && !pop_ok) begin
      fifo_cnt_d = fifo_cnt + CW'(1);
    end else if (!push_ok && pop_ok) begin
      fifo_cnt_d = fifo_cnt - CW'(1);
    end
  end

  // Stall one window early so the term already in flight still fits
  assign en_d = !(((fifo_cnt_d == CW'(FIFO_DEPTH - 1)) &&
                   (cnt_d == TW'(NUM_TERMS - 1))) ||
                  (fifo_cnt_d == CW'(FIFO_DEPTH)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_q | (push & ~push_ok);
      en_q    <= en_d;
    end
  end

  pix_sum_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.i_sum_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_cnt)
  );

  assign bus.o_enable       = en_q;
  assign bus.o_sum          = head;
  assign bus.o_sum_valid    = ~empty;
  assign bus.o_fifo_count   = fifo_cnt;
  assign bus.o_protocol_err = perr_q;
  assign bus.o_overflow     = ovf_q;

endmodule

// File: tb/tb_pix_product_accumulator.sv
// Scenario and randomized bench for pix_product_accumulator against
// a window-level reference model.
module tb_pix_product_accumulator;

  localparam int BW = 8;
  localparam int N  = 9;
  localparam int D  = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  always #5 i_clk = ~i_clk;

  pix_product_accumulator_if #(
    .BIT_WIDTH (BW),
    .NUM_TERMS (N),
    .FIFO_DEPTH(D)
  ) bus ();

  pix_product_accumulator #(
    .BIT_WIDTH (BW),
    .NUM_TERMS (N),
    .FIFO_DEPTH(D)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit m_in;
  int m_acc;
  int m_cnt;
  int m_q[$];
  bit m_ovf;
  bit m_perr;
  bit m_en;

  function automatic int m_head();
    return (m_q.size() != 0) ? m_q[0] : 0;
  endfunction

  // Advance one clock and apply the window rules to the model
  task automatic tick();
    bit v, s, r, pop, push, perr;
    int p, val;
    v = bus.i_product_valid;
    s = bus.i_product_start;
    r = bus.i_sum_ready;
    p = int'(bus.i_product);
    @(posedge i_clk);
    if (i_rst) begin
      m_in = 0; m_acc = 0; m_cnt = 0; m_q.delete();
      m_ovf = 0; m_perr = 0; m_en = 1;
    end else begin
      pop = (m_q.size() != 0) && r;
      push = 0; val = 0; perr = 0;
      if (v) begin
        if (!m_in) begin
          if (!s) perr = 1;
          else if (N == 1) begin push = 1; val = p; end
          else begin m_in = 1; m_acc = p; m_cnt = 1; end
        end else if (s) begin
          perr = 1; m_acc = p; m_cnt = 1;
        end else if (m_cnt + 1 == N) begin
          push = 1; val = m_acc + p;
          m_in = 0; m_acc = 0; m_cnt = 0;
        end else begin
          m_acc += p; m_cnt++;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < D) m_q.push_back(val);
        else m_ovf = 1;
      end
      m_perr = perr;
      m_en = !((m_q.size() == D - 1 && m_cnt == N - 1) ||
               m_q.size() == D);
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input int p);
    bus.i_product_valid = v;
    bus.i_product_start = s;
    bus.i_product = 16'(p);
    tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive(0, 0, 0);
    i_rst = 1'b0;
  endtask

  task automatic drain();
    bus.i_sum_ready = 1'b1;
    for (int i = 0; i < D; i++) drive(0, 0, 0);
    bus.i_sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_sum_ready = 1'b1;
    i_rst = 1'b1;
    drive(1, 1, 16'h1234);
    i_rst = 1'b0;
    bus.i_sum_ready = 1'b0;
    n_cmp++;
    if (bus.o_sum !== 0 || bus.o_sum_valid !== 0) begin
      n_err++;
      $display("FAIL reset_sum: got %0h/%0b want 0/0", bus.o_sum, bus.o_sum_valid);
    end
    n_cmp++;
    if (bus.o_fifo_count !== 0 || bus.o_protocol_err !== 0 || bus.o_overflow !== 0) begin
      n_err++;
      $display("FAIL reset_status: got cnt=%0d perr=%0b ovf=%0b want 0/0/0",
               bus.o_fifo_count, bus.o_protocol_err, bus.o_overflow);
    end
    n_cmp++;
    if (bus.o_enable !== 1'b1) begin
      n_err++;
      $display("FAIL reset_enable: got %0b want 1", bus.o_enable);
    end
  endtask

  task automatic test_max_products();
    bit saw_perr = 0;
    int exp = 9 * 16'hFE01;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i == N - 1 && bus.o_sum_valid !== 1'b0) begin
        n_err++;
        $display("FAIL max_early_valid: got %0b want 0", bus.o_sum_valid);
      end
      drive(1, i == 0, 16'hFE01);
      if (bus.o_protocol_err) saw_perr = 1;
    end
    n_cmp++;
    if (bus.o_sum_valid !== 1'b1 || bus.o_sum !== 20'(exp) || exp != m_head()) begin
      n_err++;
      $display("FAIL max_sum: got %0h/%0b want %0h/1", bus.o_sum, bus.o_sum_valid, exp);
    end
    n_cmp++;
    if (saw_perr) begin
      n_err++;
      $display("FAIL max_perr: got 1 want 0");
    end
    drain();
  endtask

  task automatic test_gaps();
    for (int t = 1; t <= N; t++) begin
      drive(1, t == 1, t);
      if (t == 4) begin
        drive(0, 0, 0);
        drive(0, 0, 0);
      end
      if (t == N - 1) begin
        n_cmp++;
        if (bus.o_sum_valid !== 1'b0) begin
          n_err++;
          $display("FAIL gap_early: got %0b want 0", bus.o_sum_valid);
        end
      end
    end
    n_cmp++;
    if (bus.o_sum_valid !== 1'b1 || bus.o_sum !== 20'd45 || m_head() != 45) begin
      n_err++;
      $display("FAIL gap_sum: got %0d/%0b want 45/1", bus.o_sum, bus.o_sum_valid);
    end
    drain();
  endtask

  task automatic test_restart();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 10);
      pulses += bus.o_protocol_err;
    end
    for (int i = 0; i < N; i++) begin
      drive(1, i == 0, 7);
      pulses += bus.o_protocol_err;
      if (i == 0) begin
        n_cmp++;
        if (bus.o_protocol_err !== m_perr || m_perr != 1) begin
          n_err++;
          $display("FAIL restart_perr: got %0b want 1", bus.o_protocol_err);
        end
      end
      if (i == N - 2) begin
        n_cmp++;
        if (bus.o_sum_valid !== 1'b0) begin
          n_err++;
          $display("FAIL restart_partial: got valid=%0b sum=%0d want 0", bus.o_sum_valid, bus.o_sum);
        end
      end
    end
    n_cmp++;
    if (bus.o_sum !== 20'd63 || bus.o_fifo_count !== 1 || pulses != 1) begin
      n_err++;
      $display("FAIL restart_sum: got %0d cnt=%0d pulses=%0d want 63/1/1",
               bus.o_sum, bus.o_fifo_count, pulses);
    end
    drain();
  endtask

  task automatic test_overflow();
    bit en_at_last4 = 1;
    bus.i_sum_ready = 1'b0;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < N; i++) begin
        if (w == 3 && i == N - 1) en_at_last4 = bus.o_enable;
        drive(1, i == 0, 1);
      end
    end
    n_cmp++;
    if (en_at_last4 !== 1'b0 || m_en != 0) begin
      n_err++;
      $display("FAIL ovf_enable: got %0b want 0", en_at_last4);
    end
    n_cmp++;
    if (bus.o_overflow !== 1'b1 || bus.o_fifo_count !== 4) begin
      n_err++;
      $display("FAIL ovf_state: got ovf=%0b cnt=%0d want 1/4", bus.o_overflow, bus.o_fifo_count);
    end
    n_cmp++;
    if (bus.o_sum !== 20'd9 || bus.o_enable !== m_en) begin
      n_err++;
      $display("FAIL ovf_head: got %0d en=%0b want 9 en=%0b", bus.o_sum, bus.o_enable, m_en);
    end
  endtask

  task automatic test_full_pop_push();
    int exp[5];
    int p;
    do_reset();
    bus.i_sum_ready = 1'b0;
    for (int w = 0; w < 5; w++) begin
      exp[w] = 0;
      for (int i = 0; i < N; i++) begin
        p = $urandom_range(0, 65535);
        exp[w] += p;
        if (w == 4 && i == N - 1) bus.i_sum_ready = 1'b1;
        drive(1, i == 0, p);
      end
    end
    bus.i_sum_ready = 1'b0;
    n_cmp++;
    if (bus.o_fifo_count !== 4 || bus.o_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fpp_state: got cnt=%0d ovf=%0b want 4/0", bus.o_fifo_count, bus.o_overflow);
    end
    bus.i_sum_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      n_cmp++;
      if (bus.o_sum !== 20'(exp[k]) || bus.o_sum_valid !== 1'b1) begin
        n_err++;
        $display("FAIL fpp_order%0d: got %0h want %0h", k, bus.o_sum, exp[k]);
      end
      drive(0, 0, 0);
    end
    bus.i_sum_ready = 1'b0;
    n_cmp++;
    if (bus.o_sum_valid !== 1'b0 || bus.o_sum !== 0) begin
      n_err++;
      $display("FAIL fpp_empty: got %0h/%0b want 0/0", bus.o_sum, bus.o_sum_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, i == 0, 2);
    i_rst = 1'b1;
    drive(1, 0, 2);
    i_rst = 1'b0;
    n_cmp++;
    if (bus.o_sum !== 0 || bus.o_sum_valid !== 0 || bus.o_fifo_count !== 0 ||
        bus.o_protocol_err !== 0 || bus.o_overflow !== 0 || bus.o_enable !== 1) begin
      n_err++;
      $display("FAIL midrst_out: got sum=%0h v=%0b c=%0d e=%0b o=%0b en=%0b want reset",
               bus.o_sum, bus.o_sum_valid, bus.o_fifo_count,
               bus.o_protocol_err, bus.o_overflow, bus.o_enable);
    end
    for (int i = 0; i < N; i++) drive(1, i == 0, 2);
    n_cmp++;
    if (bus.o_sum !== 20'd18 || bus.o_sum_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_sum: got %0d want 18", bus.o_sum);
    end
    drain();
  endtask

  task automatic test_random();
    bit v, s;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && (($urandom_range(0, 15) == 0) ||
                (!m_in && $urandom_range(0, 4) != 0));
      bus.i_sum_ready = ($urandom_range(0, 2) != 0);
      drive(v, s, $urandom_range(0, 65535));
      n_cmp++;
      if (bus.o_sum !== 20'(m_head()) || bus.o_sum_valid !== (m_q.size() != 0) ||
          bus.o_fifo_count !== 3'(m_q.size())) begin
        n_err++;
        $display("FAIL rnd_fifo@%0d: got %0h/%0b/%0d want %0h/%0d",
                 c, bus.o_sum, bus.o_sum_valid, bus.o_fifo_count, m_head(), m_q.size());
      end
      n_cmp++;
      if (bus.o_protocol_err !== m_perr || bus.o_overflow !== m_ovf ||
          bus.o_enable !== m_en) begin
        n_err++;
        $display("FAIL rnd_status@%0d: got e=%0b o=%0b en=%0b want %0b/%0b/%0b",
                 c, bus.o_protocol_err, bus.o_overflow, bus.o_enable, m_perr, m_ovf, m_en);
      end
    end
  endtask

  initial begin
    bus.i_product       = '0;
    bus.i_product_valid = 1'b0;
    bus.i_product_start = 1'b0;
    bus.i_sum_ready     = 1'b0;
    test_reset();
    test_max_products();
    test_gaps();
    test_restart();
    test_overflow();
    test_full_pop_push();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
